// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat hand controller.
// The state encoding and the score thresholds live here so the FSM and the draw rules agree.
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        EVAL1,
        DEAL_P3,
        EVAL2,
        DEAL_D3,
        RESULT,
        DONE
    } state_t;

    localparam logic [3:0] NATURAL_MIN     = 4'd8;
    localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
    localparam logic [3:0] BANKER_DRAW_MAX = 4'd5;
    localparam logic [3:0] SCORE_MAX       = 4'd9;

    // Codes 10..15 never come from the datapath; they must not count as a natural.
    function automatic logic is_natural(input logic [3:0] score);
        return (score >= NATURAL_MIN) && (score <= SCORE_MAX);
    endfunction

endpackage

// File: rtl/baccarat_draw_rules.sv
// Banker third-card rule, applied after the player has drawn a third card.
// Purely combinational: decides from the banker's two-card score and the player's third card.
module baccarat_draw_rules
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       banker_draw
);

    always_comb begin
        banker_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
            4'd3:             banker_draw = (pcard3 != 4'd8);
            4'd4:             banker_draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             banker_draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             banker_draw = (pcard3 == 4'd6) || (pcard3 == 4'd7);
            // 7 and any out-of-range value stand
            default:          banker_draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat deal sequencer: strobes one card load per slow_clock cycle, applies the
// third-card rules, and latches the win lights when the hand is settled.
module baccarat_ctrl
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t state_reg;
    state_t state_next;
    logic   player_win_reg;
    logic   dealer_win_reg;
    logic   banker_draw;

    baccarat_draw_rules u_draw_rules (
        .dscore      (dscore),
        .pcard3      (pcard3),
        .banker_draw (banker_draw)
    );

    // Lights are only ever written on the RESULT->DONE edge; DONE is terminal, so they hold.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_reg      <= IDLE;
            player_win_reg <= 1'b0;
            dealer_win_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RESULT) begin
                player_win_reg <= (pscore >= dscore);
                dealer_win_reg <= (pscore <= dscore);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        case (state_reg)
            IDLE:    state_next = DEAL_P1;
            DEAL_P1: begin load_pcard1 = 1'b1; state_next = DEAL_D1; end
            DEAL_D1: begin load_dcard1 = 1'b1; state_next = DEAL_P2; end
            DEAL_P2: begin load_pcard2 = 1'b1; state_next = DEAL_D2; end
            DEAL_D2: begin load_dcard2 = 1'b1; state_next = EVAL1;   end
            EVAL1: begin
                if (is_natural(pscore) || is_natural(dscore))
                    state_next = RESULT;
                else if (pscore <= PLAYER_DRAW_MAX)
                    state_next = DEAL_P3;
                else if (dscore <= BANKER_DRAW_MAX)
                    state_next = DEAL_D3;
                else
                    state_next = RESULT;
            end
            DEAL_P3: begin load_pcard3 = 1'b1; state_next = EVAL2; end
            EVAL2:   state_next = banker_draw ? DEAL_D3 : RESULT;
            DEAL_D3: begin load_dcard3 = 1'b1; state_next = RESULT; end
            RESULT:  state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    assign player_win_light = player_win_reg;
    assign dealer_win_light = dealer_win_reg;

endmodule
